c432_bist_ctrl: RTL and testbench
=================================

C432_BIST_CTRL -- requirements
Module: c432_bist_ctrl

Interface
REQ-001 Parameter CUT_LAT, default 1, cycles from pat_out change to the matching rsp_in being valid (1..4).
REQ-002 Parameter PAT_W, default 36, pattern width equal to the c432 primary-input count.
REQ-003 Parameter RSP_W, default 7, response width equal to the c432 primary-output count.
REQ-004 Parameter SIG_W, default 16, signature width.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port start  input  1  one-cycle request to begin a test run.
REQ-008 Port num_pat  input  16  number of patterns to apply.
REQ-009 Port seed  input  PAT_W  LFSR seed.
REQ-010 Port golden_sig  input  SIG_W  expected signature.
REQ-011 Port rsp_in  input  RSP_W  registered c432 outputs (Qout_PCN_223..Qout_PCN_432, LSB first).
REQ-012 Port pat_out  output  PAT_W  drives PCN1..PCN115 (PCN1 = bit 0).
REQ-013 Port pat_valid  output  1  high while pat_out carries a pattern.
REQ-014 Port busy  output  1  high from start acceptance until done.
REQ-015 Port done  output  1  one-cycle completion pulse.
REQ-016 Port pass  output  1  signature == golden_sig, valid from done until the next accepted start.
REQ-017 Port signature  output  SIG_W  final MISR contents, held until the next accepted start.

Function
REQ-018 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-019 start is accepted only in IDLE; it is ignored in every other state.
REQ-020 On acceptance at edge k: LFSR <= seed (36'h1 if seed == 0), counter <= num_pat, MISR <= 0, pass <= 0, busy <= 1, state <= RUN (DRAIN if num_pat == 0).
REQ-021 In RUN: pat_valid = 1 and pat_out = LFSR each cycle; LFSR advances every cycle; counter decrements; after exactly num_pat cycles, state <= DRAIN.
REQ-022 LFSR is Fibonacci x^36+x^25+1, shifting toward the MSB, with new bit0 = bit35 XOR bit24.
REQ-023 Outside RUN: pat_out = 0 and pat_valid = 0.
REQ-024 pat_valid is delayed CUT_LAT cycles into rsp_vld.
REQ-025 MISR updates only when rsp_vld = 1, as a Galois shift by x^16+x^14+x^13+x^11+1 XOR {9'b0, rsp_in}.
REQ-026 DRAIN lasts exactly CUT_LAT cycles so that every applied pattern's response is absorbed.
REQ-027 After DRAIN, the block enters DONE for one cycle: done = 1, busy = 0, signature <= MISR, pass <= (MISR == golden_sig); the next state is IDLE.
REQ-028 A start asserted in the DONE cycle is ignored.
REQ-029 num_pat == 0: no patterns are applied, signature = 0, and pass = (golden_sig == 0).
REQ-030 num_pat == 16'hFFFF: 65535 patterns are applied with no counter wrap.
REQ-031 Total latency from start acceptance to done = num_pat + CUT_LAT + 1 cycles.

Reset
REQ-032 While reset = 1 at a rising edge: state <= IDLE; LFSR, counter, MISR, signature, delay line <= 0; pat_out, pat_valid, busy, done, pass <= 0.
REQ-033 Reset asserted mid-run aborts the run with no done pulse and leaves the previous signature cleared; the next start behaves as the first run.

Structure
REQ-034 Package c432_bist_pkg holds the state enum, the LFSR tap constants, the MISR polynomial constant, and the PAT_W/RSP_W/SIG_W defaults.
REQ-035 MISR is a sub-module, c432_misr (clk, reset, clr, en, din, sig); the LFSR, counter and FSM stay in the top level.

Verification
REQ-036 Reset and idle: reset for 2 cycles with start = 0 -> all outputs are 0; busy never rises.
REQ-037 num_pat = 0, golden_sig = 0, start -> done 2 cycles after acceptance (CUT_LAT = 1); pass = 1, signature = 0, pat_valid never high.
REQ-038 seed = 36'h1, num_pat = 4, rsp_in = 0 -> pat_out sequence is 1, 2, 4, 8; done at acceptance + 6; signature = 0.
REQ-039 seed = 0, num_pat = 3, rsp_in = 7'h01 constant -> first pat_out = 1; signature matches the reference-model MISR value; pass tracks golden_sig match and mismatch on two runs.
REQ-040 Reset asserted 2 cycles into a 10-pattern run -> IDLE the next cycle, no done pulse; a following 4-pattern run is identical to REQ-038.
REQ-041 start held high through a run, including the DONE cycle -> exactly one run per IDLE entry; a second run begins the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/c432_bist_pkg.sv
// Shared types and constants for the c432 BIST controller: FSM states,
// pattern-generator taps, signature polynomial and default widths.
package c432_bist_pkg;

  localparam int PAT_W_DEF = 36;
  localparam int RSP_W_DEF = 7;
  localparam int SIG_W_DEF = 16;

  // Fibonacci x^36 + x^25 + 1: feedback taps are bits 35 and 24
  localparam int LFSR_TAP_HI = 35;
  localparam int LFSR_TAP_LO = 24;

  // x^16 + x^14 + x^13 + x^11 + 1 without the implicit x^16 term
  localparam logic [15:0] MISR_POLY = 16'h6801;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/c432_misr.sv
// Multiple-input signature register: Galois shift by MISR_POLY with the
// response word folded into the low bits on every enabled cycle.
module c432_misr
  import c432_bist_pkg::*;
#(
  parameter int RSP_W = RSP_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [RSP_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ SIG_W'(din);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c432_bist_ctrl.sv
// BIST controller for the c432 benchmark: LFSR pattern source, pattern
// counter and run FSM, with responses compacted by c432_misr.
module c432_bist_ctrl
  import c432_bist_pkg::*;
#(
  parameter int CUT_LAT = 1,
  parameter int PAT_W   = PAT_W_DEF,
  parameter int RSP_W   = RSP_W_DEF,
  parameter int SIG_W   = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      num_pat,
  input  logic [PAT_W-1:0] seed,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic [RSP_W-1:0] rsp_in,
  output logic [PAT_W-1:0] pat_out,
  output logic             pat_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output bist_state_e      dbg_state_o
);

  localparam logic [15:0] DRAIN_CNT = 16'(CUT_LAT);

  // Handshake: start is a request sampled only in IDLE (no ready is
  // returned; busy rises on the accepting edge). done is a single-cycle
  // pulse, coincident with busy falling and signature/pass becoming valid.

  bist_state_e      state_q, state_d;
  logic [PAT_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CUT_LAT-1:0] dly_q;

  logic             misr_clr;
  logic             rsp_vld;
  logic [SIG_W-1:0] misr_sig;
  logic [PAT_W-1:0] lfsr_step;

  assign lfsr_step = {lfsr_q[PAT_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
  assign rsp_vld   = dly_q[CUT_LAT-1];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    sig_d    = sig_q;
    misr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_d   = (seed == '0) ? PAT_W'(1) : seed;
          misr_clr = 1'b1;
          pass_d   = 1'b0;
          sig_d    = '0;
          busy_d   = 1'b1;
          // an empty run skips straight to draining the (empty) pipeline
          if (num_pat == 16'd0) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_CNT;
          end else begin
            state_d = ST_RUN;
            cnt_d   = num_pat;
          end
        end
      end
      ST_RUN: begin
        lfsr_d = lfsr_step;
        if (cnt_q == 16'd1) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_CNT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 16'd1) begin
          state_d = ST_DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        sig_d   = misr_sig;
        pass_d  = (misr_sig == golden_sig);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  // pattern-valid pipeline matching the CUT's output register latency
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= pat_valid;
      for (int i = 1; i < CUT_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  c432_misr #(
    .RSP_W (RSP_W),
    .SIG_W (SIG_W)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (misr_clr),
    .en    (rsp_vld),
    .din   (rsp_in),
    .sig   (misr_sig)
  );

  assign pat_valid   = (state_q == ST_RUN);
  assign pat_out     = pat_valid ? lfsr_q : '0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign signature   = sig_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_c432_bist_ctrl.sv
// Self-checking bench for c432_bist_ctrl: table vectors, random runs against
// an arithmetic reference model, and hand sequences for reset/start corners.
module tb_c432_bist_ctrl;
  import c432_bist_pkg::*;

  localparam int CUT_LAT = 1;
  localparam int PAT_W   = 36;
  localparam int RSP_W   = 7;
  localparam int SIG_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      num_pat;
  logic [PAT_W-1:0] seed;
  logic [SIG_W-1:0] golden_sig;
  logic [RSP_W-1:0] rsp_in;
  logic [PAT_W-1:0] pat_out;
  logic             pat_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  bist_state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PAT_W-1:0] seed;
    logic [15:0]      n;
    bit               mode;       // 0: constant response, 1: CUT function
    logic [RSP_W-1:0] rc;
    int               gmode;      // 0: literal golden, 1: model sig, 2: model sig ^ 1
    logic [SIG_W-1:0] glit;
    logic [PAT_W-1:0] exp_first;
    bit               exp_pass;
    bit               exp_sig_zero;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  c432_bist_ctrl #(
    .CUT_LAT (CUT_LAT),
    .PAT_W   (PAT_W),
    .RSP_W   (RSP_W),
    .SIG_W   (SIG_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_pat     (num_pat),
    .seed        (seed),
    .golden_sig  (golden_sig),
    .rsp_in      (rsp_in),
    .pat_out     (pat_out),
    .pat_valid   (pat_valid),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .signature   (signature),
    .dbg_state_o (dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] v);
    longint unsigned x;
    longint unsigned fb;
    x  = 64'(v);
    fb = ((x >> 35) ^ (x >> 24)) & 64'd1;
    return PAT_W'(((x << 1) | fb) & 64'hF_FFFF_FFFF);
  endfunction

  // stand-in combinational CUT: XOR-fold of the pattern into 7 bits
  function automatic logic [RSP_W-1:0] cut_f(input logic [PAT_W-1:0] p);
    return RSP_W'(p ^ (p >> 7) ^ (p >> 14) ^ (p >> 21) ^ (p >> 28));
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [PAT_W-1:0] exp_q[$];
    logic [PAT_W-1:0] l;
    logic [PAT_W-1:0] prev_pat;
    logic [PAT_W-1:0] first_pat;
    logic [PAT_W-1:0] e;
    logic [SIG_W-1:0] msig;
    logic [SIG_W-1:0] gold;
    int unsigned      m;
    int               npat, pat_err, lat;
    bit               got_done, busy_at_done, pass_at_done;
    logic [SIG_W-1:0] sig_at_done;

    // reference model: pattern list and signature as polynomial arithmetic
    m = 0;
    l = (v.seed == '0) ? PAT_W'(1) : v.seed;
    for (int i = 0; i < int'(v.n); i++) begin
      exp_q.push_back(l);
      m = m * 2;
      if (m >= 32'h10000) m = m ^ 32'h16801;
      m = m ^ 32'(v.mode ? cut_f(l) : v.rc);
      l = lfsr_next(l);
    end
    msig = SIG_W'(m);
    gold = (v.gmode == 0) ? v.glit : (v.gmode == 1) ? msig : (msig ^ 16'h0001);

    @(negedge clk);
    seed = v.seed; num_pat = v.n; golden_sig = gold; start = 1'b1;
    rsp_in = v.mode ? '0 : v.rc;
    @(negedge clk);
    start = 1'b0;
    prev_pat = '0; first_pat = '0; npat = 0; pat_err = 0; lat = -1;
    got_done = 1'b0; busy_at_done = 1'b1; pass_at_done = 1'b0; sig_at_done = '0;
    for (int d = 0; d <= int'(v.n) + CUT_LAT + 8; d++) begin
      if (d > 0) @(negedge clk);
      if (pat_valid) begin
        if (npat == 0) first_pat = pat_out;
        npat++;
        if (exp_q.size() == 0) begin
          pat_err++;
        end else begin
          e = exp_q.pop_front();
          if (pat_out !== e) pat_err++;
        end
      end
      if (v.mode) rsp_in = cut_f(prev_pat);
      prev_pat = pat_out;
      if (done) begin
        lat = d; got_done = 1'b1;
        busy_at_done = busy; pass_at_done = pass; sig_at_done = signature;
        break;
      end
    end
    chk({tag, "_done_seen"}, got_done, 1'b1);
    chk({tag, "_latency"}, lat, int'(v.n) + CUT_LAT + 1);
    chk({tag, "_pat_count"}, npat, int'(v.n));
    chk({tag, "_pat_seq_errs"}, pat_err, 0);
    chk({tag, "_signature"}, sig_at_done, msig);
    chk({tag, "_pass"}, pass_at_done, v.exp_pass);
    chk({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    if (v.n != 16'd0) chk({tag, "_first_pat"}, first_pat, v.exp_first);
    if (v.exp_sig_zero) chk({tag, "_sig_zero"}, sig_at_done, 16'h0000);
  endtask

  initial begin
    int   busy_seen, done_cnt, done1, done2;
    bit   pv4, pv5, busy4, busy5;
    vec_t rv;

    reset = 1'b1; start = 1'b0; num_pat = '0; seed = '0; golden_sig = '0; rsp_in = '0;

    // reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pat_out", pat_out, '0);
    chk("rst_pat_valid", pat_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_signature", signature, '0);
    chk("rst_state", dbg_state, ST_IDLE);
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("idle_busy_never", busy_seen, 0);

    vecs[0] = '{36'h1, 16'd4, 1'b0, 7'h00, 0, 16'h0000, 36'h1, 1'b1, 1'b1};
    vecs[1] = '{36'h0, 16'd0, 1'b0, 7'h00, 0, 16'h0000, 36'h1, 1'b1, 1'b1};
    vecs[2] = '{36'h0, 16'd0, 1'b0, 7'h55, 0, 16'h1234, 36'h1, 1'b0, 1'b1};
    vecs[3] = '{36'h0, 16'd3, 1'b0, 7'h01, 1, 16'h0000, 36'h1, 1'b1, 1'b0};
    vecs[4] = '{36'h0, 16'd3, 1'b0, 7'h01, 2, 16'h0000, 36'h1, 1'b0, 1'b0};
    vecs[5] = '{36'h9_ABCD_1234, 16'd20, 1'b1, 7'h00, 1, 16'h0000, 36'h9_ABCD_1234, 1'b1, 1'b0};
    vecs[6] = '{36'h8_0000_0001, 16'hFFFF, 1'b1, 7'h00, 2, 16'h0000, 36'h8_0000_0001, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      rv.seed      = {4'($urandom_range(15, 0)), 32'($urandom())};
      rv.n         = 16'($urandom_range(40, 0));
      rv.mode      = 1'($urandom_range(1, 0));
      rv.rc        = 7'($urandom_range(127, 0));
      rv.gmode     = int'($urandom_range(2, 1));
      rv.glit      = '0;
      rv.exp_first = (rv.seed == '0) ? 36'h1 : rv.seed;
      rv.exp_pass  = (rv.gmode == 1);
      rv.exp_sig_zero = 1'b0;
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // reset two cycles into a 10-pattern run
    @(negedge clk);
    seed = 36'h1; num_pat = 16'd10; golden_sig = '0; rsp_in = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_busy", busy, 1'b0);
    chk("abort_pat_valid", pat_valid, 1'b0);
    chk("abort_signature", signature, '0);
    done_cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_vec(vecs[0], "post_abort");

    // start held high: one run per IDLE entry, DONE-cycle start ignored
    @(negedge clk);
    seed = 36'h5; num_pat = 16'd2; golden_sig = '0; rsp_in = '0; start = 1'b1;
    done_cnt = 0; done1 = -1; done2 = -1;
    pv4 = 1'b1; pv5 = 1'b0; busy4 = 1'b1; busy5 = 1'b0;
    for (int d = 0; d <= 10; d++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done1 < 0) done1 = d; else if (done2 < 0) done2 = d;
      end
      if (d == 4) begin pv4 = pat_valid; busy4 = busy; end
      if (d == 5) begin pv5 = pat_valid; busy5 = busy; end
    end
    chk("held_done_count", done_cnt, 2);
    chk("held_first_done", done1, 4);
    chk("held_second_done", done2, 9);
    chk("held_pv_at_done", pv4, 1'b0);
    chk("held_busy_at_done", busy4, 1'b0);
    chk("held_restart_pv", pv5, 1'b1);
    chk("held_restart_busy", busy5, 1'b1);
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
